// File: rtl/y_serial_arbiter.sv
// Two-requester round-robin arbiter that serialises the granted WIDTH-bit
// pattern MSB-first onto Y, with a one-cycle done pulse per transfer.
module y_serial_arbiter #(
  parameter int unsigned WIDTH  = 8,
  parameter logic        IDLE_Y = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             Y,
  output logic             y_valid,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-2:0] rest;     // bits still to be sent; the current bit lives in Y
  logic [CNT_W-1:0] cnt;
  logic             rr_last;  // requester served by the last completed transfer

  logic             pick1_c;
  logic [WIDTH-1:0] sel_data_c;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick1_c    = req1 & (~req0 | ~rr_last);
  assign sel_data_c = pick1_c ? data1 : data0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rest    <= '0;
      cnt     <= '0;
      rr_last <= 1'b1;
      Y       <= IDLE_Y;
      y_valid <= 1'b0;
      gnt     <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state   <= SHIFT;
            gnt     <= pick1_c ? 2'b10 : 2'b01;
            Y       <= sel_data_c[WIDTH-1];
            rest    <= sel_data_c[WIDTH-2:0];
            cnt     <= CNT_W'(WIDTH - 1);
            y_valid <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            state   <= DONE;
            Y       <= IDLE_Y;
            y_valid <= 1'b0;
            done    <= 1'b1;
          end else begin
            Y    <= rest[WIDTH-2];
            rest <= rest << 1;
            cnt  <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          rr_last <= gnt[1];
          gnt     <= 2'b00;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          Y       <= IDLE_Y;
          y_valid <= 1'b0;
          gnt     <= 2'b00;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_serial_arbiter.sv
// Directed bench for y_serial_arbiter (WIDTH=8): reset, serial patterns,
// round-robin ties, reset abort and data stability after grant.
module tb_y_serial_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       Y, y_valid, busy, done;
  logic [1:0] gnt;

  int checks   = 0;
  int failures = 0;

  y_serial_arbiter #(.WIDTH(8), .IDLE_Y(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .data0  (data0),
    .req1   (req1),
    .data1  (data1),
    .Y      (Y),
    .y_valid(y_valid),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".Y"},       32'(Y),       32'(1));
    check({tag, ".y_valid"}, 32'(y_valid), 32'(0));
    check({tag, ".gnt"},     32'(gnt),     32'(0));
    check({tag, ".busy"},    32'(busy),    32'(0));
    check({tag, ".done"},    32'(done),    32'(0));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the request(s) driven and the DUT in IDLE.
  // Checks the 8 bits, the done cycle and the following idle cycle.
  // When clr is set, requests drop and data is zeroed right after the grant.
  task automatic expect_xfer(input string tag, input logic [1:0] g,
                             input logic [7:0] d, input bit clr);
    for (int i = 0; i < 8; i++) begin
      tick();
      check({tag, ".bit"},   32'(Y),       32'(d[7-i]));
      check({tag, ".valid"}, 32'(y_valid), 32'(1));
      check({tag, ".gnt"},   32'(gnt),     32'(g));
      check({tag, ".busy"},  32'(busy),    32'(1));
      check({tag, ".done0"}, 32'(done),    32'(0));
      if (i == 0 && clr) begin
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
      end
    end
    tick();
    check({tag, ".done"},       32'(done),    32'(1));
    check({tag, ".done_valid"}, 32'(y_valid), 32'(0));
    check({tag, ".done_Y"},     32'(Y),       32'(1));
    check({tag, ".done_gnt"},   32'(gnt),     32'(g));
    check({tag, ".done_busy"},  32'(busy),    32'(1));
    tick();
    check_idle({tag, ".after"});
  endtask

  initial begin
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = 8'h00;
    data1 = 8'h00;

    // Reset held two cycles, then quiet idle
    tick();
    check_idle("rst1");
    tick();
    check_idle("rst2");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("quiet");
    end

    // Single requester 0, 8'hB4
    req0  = 1'b1;
    data0 = 8'hB4;
    expect_xfer("r0_b4", 2'b01, 8'hB4, 1'b1);

    // Fresh reset, then simultaneous requests: requester 0 first, then 1
    reset = 1'b1;
    tick();
    check_idle("rst3");
    reset = 1'b0;
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 8'hFF;
    data1 = 8'h00;
    expect_xfer("tie_ff", 2'b01, 8'hFF, 1'b0);
    expect_xfer("tie_00", 2'b10, 8'h00, 1'b1);

    // Both held for four transfers: grants alternate starting with 01
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 8'h5A;
    data1 = 8'hC3;
    expect_xfer("rr1", 2'b01, 8'h5A, 1'b0);
    expect_xfer("rr2", 2'b10, 8'hC3, 1'b0);
    expect_xfer("rr3", 2'b01, 8'h5A, 1'b0);
    expect_xfer("rr4", 2'b10, 8'hC3, 1'b1);

    // Reset during the 4th bit of an 8'hA5 transfer on requester 1
    req1  = 1'b1;
    data1 = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort.bit", 32'(Y),   32'(i % 2 == 0));
      check("abort.gnt", 32'(gnt), 32'(2'b10));
    end
    reset = 1'b1;
    req1  = 1'b0;
    tick();
    check_idle("abort_rst1");
    tick();
    check_idle("abort_rst2");
    reset = 1'b0;
    tick();
    check_idle("abort_post");

    // Requester 1 alone after abort is served normally
    req1  = 1'b1;
    data1 = 8'h96;
    expect_xfer("r1_96", 2'b10, 8'h96, 1'b1);

    // One-cycle pulse on req1 with data1 changed right after the grant
    req1  = 1'b1;
    data1 = 8'h3C;
    expect_xfer("pulse_3c", 2'b10, 8'h3C, 1'b1);

    tick();
    check_idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
